// File: rtl/btb_predict_check.sv
// rtl/btb_predict_check.sv - direct-mapped BTB with 2-bit counters, resolve check and perf counters
module btb_predict_check #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b10,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             resolve, incorrect;
    logic             write_alloc, write_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Lookup sees pre-edge contents only; no bypass from a same-cycle update.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    assign resolve   = ex_valid && ex_is_branch;
    assign incorrect = (ex_pred_taken != ex_taken) ||
                       (ex_pred_taken && ex_taken && (ex_pred_target != ex_target));
    assign redirect    = resolve && incorrect;
    assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign write_hit   = resolve && ex_hit;
    assign write_alloc = resolve && !ex_hit && ex_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (write_alloc) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= INIT_CTR;
        end else if (write_hit) begin
            if (ex_taken && ctr_q[ex_idx] != 2'b11)
                ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            else if (!ex_taken && ctr_q[ex_idx] != 2'b00)
                ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
    end

    // Tag/target need no reset: a cleared valid bit masks them.
    always_ff @(posedge clk) begin
        if (!reset && (write_alloc || (write_hit && ex_taken))) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (perf_clr) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (resolve && br_count != {CNT_W{1'b1}})
                br_count <= br_count + 1'b1;
            if (redirect && mis_count != {CNT_W{1'b1}})
                mis_count <= mis_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_btb_predict_check.sv
// tb/tb_btb_predict_check.sv - self-checking bench for btb_predict_check
module tb_btb_predict_check;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc = 32'h0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_pred_taken = 1'b0;
    logic [31:0] ex_pc = 32'h0, ex_target = 32'h0, ex_pred_target = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        perf_clr = 1'b0;
    logic [3:0]  br_count, mis_count;

    int compared = 0;
    int mismatched = 0;

    btb_predict_check #(.ENTRIES(16), .INIT_CTR(2'b10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .perf_clr(perf_clr), .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each slot remembers the full PC that owns it.
    bit              m_vld [16];
    int unsigned     m_own [16];
    int unsigned     m_tgt [16];
    int              m_ctr [16];
    int              m_br, m_mis;

    function automatic int slot(input int unsigned pc);
        return (pc / 4) % 16;
    endfunction

    function automatic bit owns(input int unsigned pc);
        return m_vld[slot(pc)] && (m_own[slot(pc)] / 64 == pc / 64);
    endfunction

    function automatic bit m_wrong();
        return (ex_pred_taken != ex_taken) ||
               (ex_pred_taken && ex_taken && ex_pred_target != ex_target);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin m_vld[i] = 0; m_ctr[i] = 0; end
            m_br = 0; m_mis = 0;
        end else begin
            if (ex_valid && ex_is_branch) begin
                int s;
                s = slot(ex_pc);
                if (owns(ex_pc)) begin
                    if (ex_taken) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = ex_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (ex_taken) begin
                    m_vld[s] = 1; m_own[s] = ex_pc; m_tgt[s] = ex_target; m_ctr[s] = 2;
                end
            end
            if (perf_clr) begin
                m_br = 0; m_mis = 0;
            end else if (ex_valid && ex_is_branch) begin
                m_br = (m_br < 15) ? m_br + 1 : 15;
                if (m_wrong()) m_mis = (m_mis < 15) ? m_mis + 1 : 15;
            end
        end
    end

    always @(negedge clk) begin
        bit e_pt, e_rd;
        e_pt = owns(if_pc) && m_ctr[slot(if_pc)] >= 2;
        e_rd = ex_valid && ex_is_branch && m_wrong();
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
        chk("pred_target", pred_target, e_pt ? m_tgt[slot(if_pc)] : if_pc + 32'd4);
        chk("redirect", {31'd0, redirect}, {31'd0, e_rd});
        if (e_rd)
            chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
        chk("br_count", {28'd0, br_count}, m_br);
        chk("mis_count", {28'd0, mis_count}, m_mis);
    end

    task automatic cyc(input logic rst, input logic clr, input logic [31:0] ipc,
                       input logic ev, input logic eb, input logic [31:0] epc,
                       input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        @(posedge clk); #1;
        reset = rst; perf_clr = clr; if_pc = ipc;
        ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
        @(negedge clk); #1;
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(0, 0, ipc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        idle(32'h100);
        chk("cold_pt", {31'd0, pred_taken}, 0);
        chk("cold_tgt", pred_target, 32'h104);
        chk("cold_br", {28'd0, br_count}, 0);

        cyc(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        chk("alloc_rd", {31'd0, redirect}, 1);
        chk("alloc_rpc", redirect_pc, 32'h200);
        chk("alloc_nobypass", {31'd0, pred_taken}, 0);
        idle(32'h100);
        chk("alloc_pt", {31'd0, pred_taken}, 1);
        chk("alloc_tgt", pred_target, 32'h200);
        chk("alloc_br", {28'd0, br_count}, 1);
        chk("alloc_mis", {28'd0, mis_count}, 1);

        cyc(0, 0, 32'h100, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        chk("hyst_rpc", redirect_pc, 32'h104);
        cyc(0, 0, 32'h100, 1, 1, 32'h100, 0, 32'h0, 0, 32'h104);
        chk("hyst_ctr01", {31'd0, pred_taken}, 0);
        chk("hyst_nord", {31'd0, redirect}, 0);
        cyc(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        cyc(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        chk("hyst_ctr01b", {31'd0, pred_taken}, 0);

        cyc(0, 0, 32'h100, 1, 1, 32'h100, 1, 32'h300, 1, 32'h200);
        chk("hyst_ctr10", {31'd0, pred_taken}, 1);
        chk("wt_rd", {31'd0, redirect}, 1);
        chk("wt_rpc", redirect_pc, 32'h300);
        chk("cnt_br5", {28'd0, br_count}, 5);
        chk("cnt_mis4", {28'd0, mis_count}, 4);

        cyc(0, 0, 32'h100, 1, 0, 32'h100, 1, 32'h900, 0, 32'h104);
        chk("wt_tgt", pred_target, 32'h300);
        chk("nb_rd", {31'd0, redirect}, 0);

        cyc(0, 0, 32'h140, 1, 1, 32'h140, 1, 32'h500, 0, 32'h144);
        chk("nb_br", {28'd0, br_count}, 6);
        idle(32'h100);
        chk("alias_miss", {31'd0, pred_taken}, 0);
        chk("alias_miss_tgt", pred_target, 32'h104);
        cyc(0, 0, 32'h140, 1, 1, 32'h180, 0, 32'h0, 0, 32'h184);
        chk("alias_hit_tgt", pred_target, 32'h500);
        idle(32'h140);
        chk("nt_miss_keep", pred_target, 32'h500);

        cyc(1, 0, 32'h240, 1, 1, 32'h240, 1, 32'h700, 0, 32'h244);
        chk("rst_rd", {31'd0, redirect}, 1);
        chk("rst_br", {28'd0, br_count}, 0);
        idle(32'h240);
        chk("rst_discard", pred_target, 32'h244);

        for (int i = 0; i < 17; i++)
            cyc(0, 0, 32'h300, 1, 1, 32'h300, 1, 32'h400, 0, 32'h304);
        chk("sat_mis16", {28'd0, mis_count}, 4'hF);
        idle(32'h300);
        chk("sat_mis17", {28'd0, mis_count}, 4'hF);
        chk("sat_br17", {28'd0, br_count}, 4'hF);
        cyc(0, 1, 32'h300, 1, 1, 32'h300, 1, 32'h400, 0, 32'h304);
        idle(32'h300);
        chk("clr_br", {28'd0, br_count}, 0);
        chk("clr_mis", {28'd0, mis_count}, 0);
        chk("clr_table", pred_target, 32'h400);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btb_predict_check.md
BTB_PREDICT_CHECK -- requirements
Module: btb_predict_check

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries (power of two, 2..256); IDX_W = log2(ENTRIES).
REQ-002 Parameter INIT_CTR, default 2'b10, 2-bit counter value written on allocation.
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 if_pc  in  32  fetch PC to look up.
REQ-008 pred_taken  out  1  fetch-stage taken prediction.
REQ-009 pred_target  out  32  predicted next PC.
REQ-010 ex_valid  in  1  a resolved instruction is present in EX this cycle.
REQ-011 ex_is_branch  in  1  EX instruction is a branch or jump.
REQ-012 ex_pc  in  32  PC of the EX instruction.
REQ-013 ex_taken  in  1  actual branch outcome.
REQ-014 ex_target  in  32  actual taken target.
REQ-015 ex_pred_taken  in  1  prediction carried down the pipe for this instruction.
REQ-016 ex_pred_target  in  32  predicted next PC carried down the pipe.
REQ-017 redirect  out  1  misprediction; fetch must jump to redirect_pc and younger instructions are flushed.
REQ-018 redirect_pc  out  32  correct next PC.
REQ-019 perf_clr  in  1  synchronous clear of the performance counters.
REQ-020 br_count  out  CNT_W  resolved branches since reset/clear.
REQ-021 mis_count  out  CNT_W  mispredictions since reset/clear.

Function
REQ-022 Entry fields: valid (1), tag (30-IDX_W bits), target (32), ctr (2); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-023 Lookup is combinational: hit = valid[idx] and tag match; pred_taken = hit and ctr[1]; pred_target = target if pred_taken, else if_pc+4 (mod 2^32).
REQ-024 Lookup reads pre-edge table contents; a same-cycle update to the same index is not bypassed.
REQ-025 Resolve (ex_valid and ex_is_branch) is combinational: incorrect when ex_pred_taken != ex_taken, or when both are 1 and ex_pred_target != ex_target.
REQ-026 redirect = resolve and incorrect; redirect_pc = ex_target if ex_taken, else ex_pc+4; redirect_pc is don't-care when redirect = 0.
REQ-027 Update on each clock edge with resolve, using the EX-index entry: on hit, ctr saturating +1 if taken, saturating -1 if not taken (bounds 0 and 3); target := ex_target if taken.
REQ-028 On miss and taken: allocate/overwrite the entry with valid=1, tag, target=ex_target, ctr=INIT_CTR; on miss and not taken: no change.
REQ-029 Without resolve (ex_valid=0 or ex_is_branch=0) the table SHALL NOT change.
REQ-030 br_count += 1 per resolve; mis_count += 1 per redirect; both saturate at all-ones and do not wrap.
REQ-031 perf_clr zeroes both counters on the edge and has priority over a same-cycle increment; it does not touch the table.

Reset
REQ-032 While reset is high, all valid bits, both counters and all ctr fields (to 2'b00) SHALL clear immediately, independent of clk.
REQ-033 After reset, every lookup misses: pred_taken=0, pred_target=if_pc+4.
REQ-034 Reset asserted during a resolve cycle discards that update; redirect remains combinational.

Verification (ENTRIES=16, INIT_CTR=2'b10, CNT_W=4)
REQ-035 Cold lookup: after reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-036 Allocate: resolve ex_pc=0x100, taken, ex_target=0x200, pred NT -> redirect=1, redirect_pc=0x200; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200; br_count=1, mis_count=1.
REQ-037 Hysteresis: from REQ-036 state, resolve 0x100 not taken with pred T -> redirect=1, redirect_pc=0x104, ctr=01, lookup predicts NT; second not-taken -> ctr=00; then two takens -> ctr=10 and lookup predicts T.
REQ-038 Wrong target: pred T with pred_target=0x200, actual taken to 0x300 -> redirect=1, redirect_pc=0x300; entry target becomes 0x300.
REQ-039 Alias: ex_pc=0x140 (same index as 0x100, different tag), taken to 0x500 -> entry replaced; lookup of 0x100 misses, lookup of 0x140 hits with pred_target=0x500.
REQ-040 Counters: 16 consecutive mispredictions -> mis_count saturates at 4'hF; perf_clr together with a mispredict -> both counters read 0 next cycle.
